icache_sa: RTL

//  Parametrised N-way set-associative instruction cache between the instruction fetcher and the memory controller.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_if.sv | 22 ++
 rtl/icache_way_array.sv | 49 ++++
 rtl/icache_sa.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int LINE_BYTES_DEF = 16;
  localparam int SETS_DEF       = 16;
  localparam int WAYS_DEF       = 2;

  // Address field widths for the default geometry (offset, index, tag)
  localparam int OB = clog2(LINE_BYTES_DEF);
  localparam int IB = clog2(SETS_DEF);
  localparam int TB = 32 - OB - IB;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_if;
  logic [31:0] pc;
  logic        start_fetch;
  logic        hit;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  modport master (
    output pc, start_fetch, mem_valid, mem_data,
    input  hit, inst, inst_addr, mem_req, mem_addr
  );

  modport slave (
    input  pc, start_fetch, mem_valid, mem_data,
    output hit, inst, inst_addr, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_way_array.sv
// One cache way: per-set valid/tag and line data, combinational read, single-word write.
module icache_way_array #(
  parameter int SETS  = 16,
  parameter int WORDS = 4,
  parameter int IDX_W = 4,
  parameter int CNT_W = 2,
  parameter int TAG_W = 24
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [CNT_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_word,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [CNT_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic             fill_en,
  input  logic [TAG_W-1:0] fill_tag
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS][WORDS];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_word  = data_mem[rd_idx][rd_off];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid <= '0;
    end else begin
      if (inv_en)  valid[inv_idx] <= 1'b0;
      if (fill_en) valid[wr_idx]  <= 1'b1;
    end
  end

  // Storage needs no reset: nothing is read while the valid bit is clear
  always_ff @(posedge clk_in) begin
    if (wr_en)   data_mem[wr_idx][wr_off] <= wr_data;
    if (fill_en) tag_mem[wr_idx] <= fill_tag;
  end

endmodule

// File: rtl/icache_sa.sv
// N-way set-associative blocking instruction cache with word-serial refill.
// Optional ICACHE_STATS_EN adds hit_cnt/miss_cnt outputs.
//   state  | meaning
//   IDLE   | lookups served combinationally; a miss launches a refill
//   REFILL | mem_req held, one word written per accepted mem_valid
module icache_sa
  import icache_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int SETS       = SETS_DEF,
  parameter int WAYS       = WAYS_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int WORDS = LINE_BYTES / 4;
  localparam int OFF_W = clog2(LINE_BYTES);
  localparam int IDX_W = clog2(SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W;
  localparam int CNT_W = (WORDS > 1) ? clog2(WORDS) : 1;
  localparam int RR_W  = (WAYS > 1) ? clog2(WAYS) : 1;

  state_t           state;
  logic [RR_W-1:0]  rr [SETS];
  logic [RR_W-1:0]  victim;

  logic [IDX_W-1:0] pc_idx, fill_idx;
  logic [TAG_W-1:0] pc_tag, fill_tag;
  logic [CNT_W-1:0] pc_off, fill_off;

  logic [WAYS-1:0]  way_valid;
  logic [TAG_W-1:0] way_tag  [WAYS];
  logic [31:0]      way_word [WAYS];
  logic [WAYS-1:0]  inv_sel, wr_sel, fill_sel;

  logic        lookup_ok, hit_any, start_refill, word_take, last_word;
  logic [31:0] hit_word;

  assign pc_idx = bus.pc[OFF_W+IDX_W-1:OFF_W];
  assign pc_tag = bus.pc[31:OFF_W+IDX_W];
  // During refill mem_addr carries the line tag/index and the word counter
  assign fill_idx = bus.mem_addr[OFF_W+IDX_W-1:OFF_W];
  assign fill_tag = bus.mem_addr[31:OFF_W+IDX_W];

  generate
    if (WORDS > 1) begin : g_off
      assign pc_off   = bus.pc[OFF_W-1:2];
      assign fill_off = bus.mem_addr[OFF_W-1:2];
    end else begin : g_off_single
      assign pc_off   = '0;
      assign fill_off = '0;
    end
  endgenerate

  assign lookup_ok    = rdy_in && bus.start_fetch && !rob_clear_up && (state == IDLE);
  assign start_refill = lookup_ok && !hit_any;
  assign word_take    = (state == REFILL) && rdy_in && bus.mem_valid;
  assign last_word    = (fill_off == CNT_W'(WORDS - 1));

  always_comb begin
    hit_any  = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == pc_tag)) begin
        hit_any  = 1'b1;
        hit_word = way_word[w];
      end
    end
  end

  always_comb begin
    inv_sel  = '0;
    wr_sel   = '0;
    fill_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      inv_sel[w]  = start_refill && (rr[pc_idx] == RR_W'(w));
      wr_sel[w]   = word_take && (victim == RR_W'(w));
      fill_sel[w] = word_take && last_word && (victim == RR_W'(w));
    end
  end

  assign bus.hit       = lookup_ok && hit_any;
  assign bus.inst      = bus.hit ? hit_word : '0;
  assign bus.inst_addr = bus.hit ? bus.pc : '0;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way_array #(
      .SETS  (SETS),
      .WORDS (WORDS),
      .IDX_W (IDX_W),
      .CNT_W (CNT_W),
      .TAG_W (TAG_W)
    ) u_way (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rd_idx   (pc_idx),
      .rd_off   (pc_off),
      .rd_valid (way_valid[w]),
      .rd_tag   (way_tag[w]),
      .rd_word  (way_word[w]),
      .inv_en   (inv_sel[w]),
      .inv_idx  (pc_idx),
      .wr_en    (wr_sel[w]),
      .wr_idx   (fill_idx),
      .wr_off   (fill_off),
      .wr_data  (bus.mem_data),
      .fill_en  (fill_sel[w]),
      .fill_tag (fill_tag)
    );
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      victim       <= '0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (start_refill) begin
            state        <= REFILL;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= {bus.pc[31:OFF_W], OFF_W'(0)};
            victim       <= rr[pc_idx];
            rr[pc_idx]   <= (rr[pc_idx] == RR_W'(WAYS - 1)) ? '0 : rr[pc_idx] + 1'b1;
          end
        end
        REFILL: begin
          if (bus.mem_valid) begin
            if (last_word) begin
              state       <= IDLE;
              bus.mem_req <= 1'b0;
            end else begin
              bus.mem_addr <= bus.mem_addr + 32'd4;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy_in) begin
      if (bus.hit)     hit_cnt  <= hit_cnt + 32'd1;
      if (start_refill) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
